// File: rtl/sm83_adr_seq.sv
// SM83 address latch/incrementer with an autonomous burst sequencer; all state moves on the falling clock edge.
// Optional feature macro: SM83_ADR_SEQ_STEP2_EN (adds ctl_inc_step2, doubling the step magnitude).
module sm83_adr_seq #(
    parameter int WIDTH = 16,
    parameter int HI_W  = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ain,
    output logic [WIDTH-1:0] aout,
    output logic [WIDTH-1:0] apin,
    input  logic             ctl_al_we,
    input  logic             ctl_al_hi_ff,
    input  logic             ctl_inc_dec,
    input  logic             ctl_inc_cy,
    input  logic             ctl_inc_oe,
`ifdef SM83_ADR_SEQ_STEP2_EN
    input  logic             ctl_inc_step2,
`endif
    input  logic             burst_start,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             burst_dir,
    input  logic             burst_step,
    output logic             burst_busy,
    output logic             burst_done,
    output logic             inc_wrap
);

    localparam int LO_W = WIDTH - HI_W;
    localparam logic [WIDTH:0]   STEP_ONE = 1;
    localparam logic [WIDTH:0]   STEP_TWO = 2;
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] al, al_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic [WIDTH:0]   step_mag;
    logic [WIDTH:0]   step_s;
    logic [WIDTH:0]   inc_full;
    logic             inc_dir;
    logic [WIDTH-1:0] inc;
    logic [HI_W-1:0]  ain_hi_sel;
    logic [WIDTH-1:0] base_val;
    logic [WIDTH-1:0] load_val;

    always_comb begin
`ifdef SM83_ADR_SEQ_STEP2_EN
        step_mag = ctl_inc_step2 ? STEP_TWO : STEP_ONE;
`else
        step_mag = STEP_ONE;
`endif
    end

    // The extra MSB of the widened add/subtract is exactly the carry/borrow out of the address.
    always_comb begin
        if (state == BURST) begin
            inc_dir = burst_dir;
            step_s  = step_mag;
        end else begin
            inc_dir = ctl_inc_dec;
            step_s  = ctl_inc_cy ? step_mag : '0;
        end
        if (inc_dir)
            inc_full = {1'b0, al} - step_s;
        else
            inc_full = {1'b0, al} + step_s;
        inc      = inc_full[WIDTH-1:0];
        inc_wrap = inc_full[WIDTH];
    end

    always_comb begin
        ain_hi_sel = ctl_al_hi_ff ? {HI_W{1'b1}} : ain[WIDTH-1 -: HI_W];
        base_val   = {ain_hi_sel, ain[LO_W-1:0]};
        load_val   = ctl_inc_oe ? inc : base_val;
    end

    always_comb begin
        state_nxt = state;
        al_nxt    = al;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (ctl_al_we) begin
                    al_nxt = load_val;
                end else if (burst_start) begin
                    al_nxt = base_val;
                    if (burst_len != '0) begin
                        cnt_nxt   = burst_len;
                        state_nxt = BURST;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            BURST: begin
                // A manual load aborts the burst silently and wins over a same-cycle step.
                if (ctl_al_we) begin
                    al_nxt    = load_val;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (burst_step) begin
                    al_nxt  = inc;
                    cnt_nxt = cnt - CNT_ONE;
                    if (cnt == CNT_ONE)
                        state_nxt = DONE;
                end
            end
            DONE: begin
                if (ctl_al_we)
                    al_nxt = load_val;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            al    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            al    <= al_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign aout       = al;
    assign apin       = al_nxt;
    assign burst_busy = (state == BURST);
    assign burst_done = (state == DONE);

endmodule

// File: tb/tb_sm83_adr_seq.sv
// Self-checking bench for sm83_adr_seq: scoreboard of expected aout values plus inline flag checks.
module tb_sm83_adr_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ain;
    logic [15:0] aout;
    logic [15:0] apin;
    logic        ctl_al_we, ctl_al_hi_ff, ctl_inc_dec, ctl_inc_cy, ctl_inc_oe;
`ifdef SM83_ADR_SEQ_STEP2_EN
    logic        ctl_inc_step2;
`endif
    logic        burst_start;
    logic [7:0]  burst_len;
    logic        burst_dir, burst_step;
    logic        burst_busy, burst_done, inc_wrap;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    sm83_adr_seq #(.WIDTH(16), .HI_W(8), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .ain          (ain),
        .aout         (aout),
        .apin         (apin),
        .ctl_al_we    (ctl_al_we),
        .ctl_al_hi_ff (ctl_al_hi_ff),
        .ctl_inc_dec  (ctl_inc_dec),
        .ctl_inc_cy   (ctl_inc_cy),
        .ctl_inc_oe   (ctl_inc_oe),
`ifdef SM83_ADR_SEQ_STEP2_EN
        .ctl_inc_step2(ctl_inc_step2),
`endif
        .burst_start  (burst_start),
        .burst_len    (burst_len),
        .burst_dir    (burst_dir),
        .burst_step   (burst_step),
        .burst_busy   (burst_busy),
        .burst_done   (burst_done),
        .inc_wrap     (inc_wrap)
    );

    always #5 clk = ~clk;

    task automatic wait_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ctl_al_we = 0; ctl_al_hi_ff = 0; ctl_inc_dec = 0; ctl_inc_cy = 0; ctl_inc_oe = 0;
        burst_start = 0; burst_len = 0; burst_dir = 0; burst_step = 0; ain = 16'h0000;
`ifdef SM83_ADR_SEQ_STEP2_EN
        ctl_inc_step2 = 0;
`endif
    endtask

    task automatic test_reset();
        logic [15:0] e;
        reset = 1'b1;
        clear_inputs();
        wait_edge();
        wait_edge();
        checks++; if (aout !== 16'h0000) begin failures++; $display("FAIL reset_aout got=%h exp=0000", aout); end
        checks++; if (burst_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", burst_busy); end
        checks++; if (burst_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", burst_done); end
        reset = 1'b0;
        wait_edge();
        exp_q.push_back(16'h0000);
        e = exp_q.pop_front();
        checks++; if (aout !== e) begin failures++; $display("FAIL reset_hold got=%h exp=%h", aout, e); end
    endtask

    task automatic test_manual_load();
        logic [15:0] e;
        clear_inputs();
        ctl_al_we = 1; ctl_al_hi_ff = 1; ain = 16'h1280;
        #1;
        checks++; if (apin !== 16'hFF80) begin failures++; $display("FAIL hi_ff_apin got=%h exp=FF80", apin); end
        exp_q.push_back(16'hFF80);
        wait_edge();
        e = exp_q.pop_front();
        checks++; if (aout !== e) begin failures++; $display("FAIL hi_ff_aout got=%h exp=%h", aout, e); end
        // inc_oe must win over hi_ff
        ctl_inc_oe = 1; ctl_inc_cy = 1; ctl_inc_dec = 0; ain = 16'h0000;
        #1;
        checks++; if (apin !== 16'hFF81) begin failures++; $display("FAIL inc_oe_apin got=%h exp=FF81", apin); end
        checks++; if (inc_wrap !== 1'b0) begin failures++; $display("FAIL inc_oe_wrap got=%b exp=0", inc_wrap); end
        exp_q.push_back(16'hFF81);
        wait_edge();
        e = exp_q.pop_front();
        checks++; if (aout !== e) begin failures++; $display("FAIL inc_oe_aout got=%h exp=%h", aout, e); end
        ctl_inc_oe = 0; ctl_al_hi_ff = 0; ain = 16'h1280;
        exp_q.push_back(16'h1280);
        wait_edge();
        e = exp_q.pop_front();
        checks++; if (aout !== e) begin failures++; $display("FAIL plain_load_aout got=%h exp=%h", aout, e); end
        clear_inputs();
        ain = 16'h5A5A;
        #1;
        checks++; if (apin !== 16'h1280) begin failures++; $display("FAIL idle_apin got=%h exp=1280", apin); end
    endtask

    task automatic test_incrementer();
        logic [15:0] e;
        clear_inputs();
        ctl_al_we = 1; ain = 16'hFFFF;
        exp_q.push_back(16'hFFFF);
        wait_edge();
        e = exp_q.pop_front();
        checks++; if (aout !== e) begin failures++; $display("FAIL inc_setup got=%h exp=%h", aout, e); end
        ctl_al_we = 0; ctl_inc_cy = 1; ctl_inc_dec = 0;
        #1;
        checks++; if (inc_wrap !== 1'b1) begin failures++; $display("FAIL wrap_up got=%b exp=1", inc_wrap); end
        checks++; if (apin !== 16'hFFFF) begin failures++; $display("FAIL noload_apin got=%h exp=FFFF", apin); end
        ctl_al_we = 1; ctl_inc_oe = 1;
        #1;
        checks++; if (apin !== 16'h0000) begin failures++; $display("FAIL wrap_up_apin got=%h exp=0000", apin); end
        exp_q.push_back(16'h0000);
        wait_edge();
        e = exp_q.pop_front();
        checks++; if (aout !== e) begin failures++; $display("FAIL wrap_up_aout got=%h exp=%h", aout, e); end
        ctl_al_we = 0; ctl_inc_oe = 0; ctl_inc_dec = 1;
        #1;
        checks++; if (inc_wrap !== 1'b1) begin failures++; $display("FAIL wrap_down got=%b exp=1", inc_wrap); end
        ctl_al_we = 1; ctl_inc_oe = 1;
        #1;
        checks++; if (apin !== 16'hFFFF) begin failures++; $display("FAIL wrap_down_apin got=%h exp=FFFF", apin); end
        ctl_inc_cy = 0;
        #1;
        checks++; if (inc_wrap !== 1'b0) begin failures++; $display("FAIL cy0_wrap got=%b exp=0", inc_wrap); end
        checks++; if (apin !== 16'h0000) begin failures++; $display("FAIL cy0_apin got=%h exp=0000", apin); end
        ctl_al_we = 0; ctl_inc_oe = 0; ctl_inc_dec = 0; ctl_inc_cy = 1;
        #1;
        checks++; if (inc_wrap !== 1'b0) begin failures++; $display("FAIL nowrap_up got=%b exp=0", inc_wrap); end
        clear_inputs();
    endtask

    task automatic test_burst_up();
        logic        steps  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [15:0] exp_a  [4] = '{16'hC001, 16'hC002, 16'hC002, 16'hC003};
        logic        exp_bz [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic        exp_dn [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [15:0] e;
        int busy_cycles = 0;
        clear_inputs();
        ain = 16'hC000; burst_len = 8'd3; burst_dir = 0; burst_start = 1;
        #1;
        checks++; if (apin !== 16'hC000) begin failures++; $display("FAIL bup_start_apin got=%h exp=C000", apin); end
        exp_q.push_back(16'hC000);
        wait_edge();
        e = exp_q.pop_front();
        checks++; if (aout !== e) begin failures++; $display("FAIL bup_base got=%h exp=%h", aout, e); end
        if (burst_busy === 1'b1) busy_cycles++;
        burst_start = 0; ain = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            burst_step = steps[i];
            exp_q.push_back(exp_a[i]);
            wait_edge();
            e = exp_q.pop_front();
            checks++; if (aout !== e) begin failures++; $display("FAIL bup_aout[%0d] got=%h exp=%h", i, aout, e); end
            checks++; if (burst_busy !== exp_bz[i]) begin failures++; $display("FAIL bup_busy[%0d] got=%b exp=%b", i, burst_busy, exp_bz[i]); end
            checks++; if (burst_done !== exp_dn[i]) begin failures++; $display("FAIL bup_done[%0d] got=%b exp=%b", i, burst_done, exp_dn[i]); end
            if (burst_busy === 1'b1) busy_cycles++;
        end
        burst_step = 0;
        wait_edge();
        checks++; if (burst_done !== 1'b0) begin failures++; $display("FAIL bup_done_len got=%b exp=0", burst_done); end
        checks++; if (busy_cycles != 4) begin failures++; $display("FAIL bup_busy_cycles got=%0d exp=4", busy_cycles); end
    endtask

    task automatic test_burst_down();
        logic [15:0] exp_a [4] = '{16'h0000, 16'hFFFF, 16'hFFFE, 16'hFFFD};
        logic [15:0] e;
        clear_inputs();
        ain = 16'h0001; burst_len = 8'd4; burst_dir = 1; burst_start = 1;
        exp_q.push_back(16'h0001);
        wait_edge();
        e = exp_q.pop_front();
        checks++; if (aout !== e) begin failures++; $display("FAIL bdn_base got=%h exp=%h", aout, e); end
        burst_start = 0; burst_step = 1; ctl_inc_cy = 0; ctl_inc_dec = 0;
        for (int i = 0; i < 4; i++) begin
            // a start request while bursting must be ignored
            burst_start = (i == 1); ain = (i == 1) ? 16'hAAAA : 16'h0000;
            exp_q.push_back(exp_a[i]);
            wait_edge();
            e = exp_q.pop_front();
            checks++; if (aout !== e) begin failures++; $display("FAIL bdn_aout[%0d] got=%h exp=%h", i, aout, e); end
        end
        checks++; if (burst_done !== 1'b1) begin failures++; $display("FAIL bdn_done got=%b exp=1", burst_done); end
        burst_start = 0; burst_step = 0;
        wait_edge();
        checks++; if (burst_done !== 1'b0) begin failures++; $display("FAIL bdn_done_clr got=%b exp=0", burst_done); end
        ain = 16'h5555; burst_len = 8'd0; burst_start = 1;
        exp_q.push_back(16'h5555);
        wait_edge();
        e = exp_q.pop_front();
        checks++; if (aout !== e) begin failures++; $display("FAIL len0_aout got=%h exp=%h", aout, e); end
        checks++; if (burst_busy !== 1'b0) begin failures++; $display("FAIL len0_busy got=%b exp=0", burst_busy); end
        checks++; if (burst_done !== 1'b1) begin failures++; $display("FAIL len0_done got=%b exp=1", burst_done); end
        burst_start = 0;
        wait_edge();
        checks++; if (burst_done !== 1'b0 || burst_busy !== 1'b0) begin failures++; $display("FAIL len0_after got=%b%b exp=00", burst_busy, burst_done); end
    endtask

    task automatic test_abort();
        logic [15:0] e;
        clear_inputs();
        ain = 16'h1000; burst_len = 8'd5; burst_start = 1;
        exp_q.push_back(16'h1000);
        wait_edge();
        burst_start = 0; burst_step = 1;
        exp_q.push_back(16'h1001);
        wait_edge();
        ctl_al_we = 1; ain = 16'h8000;
        exp_q.push_back(16'h8000);
        wait_edge();
        ctl_al_we = 0; burst_step = 0;
        exp_q.push_back(16'h8000);
        checks++; if (burst_busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", burst_busy); end
        checks++; if (burst_done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", burst_done); end
        wait_edge();
        checks++; if (burst_done !== 1'b0) begin failures++; $display("FAIL abort_done_late got=%b exp=0", burst_done); end
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            if (i == 3) begin
                checks++; if (aout !== e) begin failures++; $display("FAIL abort_aout got=%h exp=%h", aout, e); end
            end
        end
    endtask

    task automatic test_wrap_burst();
        logic [15:0] e;
        clear_inputs();
        ain = 16'hFFFF; burst_len = 8'd1; burst_start = 1;
        wait_edge();
        burst_start = 0; burst_step = 1;
        exp_q.push_back(16'h0000);
        wait_edge();
        e = exp_q.pop_front();
        checks++; if (aout !== e) begin failures++; $display("FAIL bwrap_aout got=%h exp=%h", aout, e); end
        checks++; if (burst_done !== 1'b1) begin failures++; $display("FAIL bwrap_done got=%b exp=1", burst_done); end
        burst_step = 0;
        wait_edge();
    endtask

    task automatic test_reset_async();
        clear_inputs();
        ain = 16'h1234; burst_len = 8'd3; burst_start = 1;
        wait_edge();
        burst_start = 0;
        checks++; if (aout !== 16'h1234 || burst_busy !== 1'b1) begin failures++; $display("FAIL rst_pre got=%h/%b exp=1234/1", aout, burst_busy); end
        reset = 1'b1;
        #1;
        checks++; if (aout !== 16'h0000) begin failures++; $display("FAIL rst_async_aout got=%h exp=0000", aout); end
        checks++; if (burst_busy !== 1'b0) begin failures++; $display("FAIL rst_async_busy got=%b exp=0", burst_busy); end
        wait_edge();
        reset = 1'b0; burst_step = 1;
        wait_edge();
        checks++; if (aout !== 16'h0000 || burst_busy !== 1'b0) begin failures++; $display("FAIL rst_after got=%h/%b exp=0000/0", aout, burst_busy); end
        clear_inputs();
    endtask

`ifdef SM83_ADR_SEQ_STEP2_EN
    task automatic test_step2();
        logic [15:0] exp_a [2] = '{16'hFFFE, 16'h0000};
        logic [15:0] e;
        clear_inputs();
        ctl_inc_step2 = 1; ain = 16'hFFFC; burst_len = 8'd2; burst_start = 1;
        exp_q.push_back(16'hFFFC);
        wait_edge();
        e = exp_q.pop_front();
        checks++; if (aout !== e) begin failures++; $display("FAIL s2_base got=%h exp=%h", aout, e); end
        burst_start = 0; burst_step = 1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(exp_a[i]);
            wait_edge();
            e = exp_q.pop_front();
            checks++; if (aout !== e) begin failures++; $display("FAIL s2_aout[%0d] got=%h exp=%h", i, aout, e); end
        end
        checks++; if (burst_done !== 1'b1) begin failures++; $display("FAIL s2_done got=%b exp=1", burst_done); end
        burst_step = 0; ctl_inc_cy = 1; ctl_inc_dec = 1; ctl_al_we = 1; ctl_inc_oe = 1;
        #1;
        checks++; if (apin !== 16'hFFFE || inc_wrap !== 1'b1) begin failures++; $display("FAIL s2_manual got=%h/%b exp=FFFE/1", apin, inc_wrap); end
        wait_edge();
        clear_inputs();
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_manual_load();
        test_incrementer();
        test_burst_up();
        test_burst_down();
        test_abort();
        test_wrap_burst();
        test_reset_async();
`ifdef SM83_ADR_SEQ_STEP2_EN
        test_step2();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
